alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Combined ALU decoder and 32-bit integer ALU for the RV32I execute stage of the 100 MHz processor. Decodes the instruction opcode, funct3 and instruction bit 30 into a 4-bit ALU operation, then applies it to operands A and B. Operand muxing (register, immediate, PC) is done upstream; this block only decodes and computes.

## Interface
Parameters:
- None. Widths are fixed: data 32 bits, ALUop 4 bits.

Ports:
- Clock  input  1  system clock; used only when the output register is compiled in.
- Reset_n  input  1  asynchronous active-low reset; used only when the output register is compiled in.
- opcode  input  7  instruction bits [6:0].
- funct  input  3  instruction funct3, bits [14:12].
- add_rshift_type  input  1  instruction bit 30; selects SUB over ADD and SRA over SRL.
- A  input  32  operand A.
- B  input  32  operand B; the immediate for I/U-type instructions.
- ALUop  output  4  decoded operation, always combinational.
- Out  output  32  ALU result.

## Operation
ALUop encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 COPY_B, 15 XXX.
- Codes 11–14 are unused and behave as XXX.

Decode rules:
- OP (0110011), by funct:
  - 000: ADD, or SUB when add_rshift_type=1.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRL, or SRA when add_rshift_type=1.
  - 110: OR. 111: AND.
- OP-IMM (0010011): same as OP, except funct=000 is always ADD; add_rshift_type is ignored for ADDI.
- LUI (0110111): COPY_B.
- ADD for AUIPC (0010111), JAL (1101111), JALR (1100111), LOAD (0000011) and STORE (0100011).
- BRANCH (1100011): ADD (target-address computation; comparison is done elsewhere).
- Any other opcode: XXX.

Execution rules:
- ADD/SUB: modulo 2^32; no overflow flag.
- Shifts: use B[4:0] only; B[31:5] is ignored. SRA replicates A[31].
- SLT: signed compare, A<B gives 1, otherwise 0; result is zero-extended. SLTU: unsigned compare, same encoding.
- COPY_B: Out = B. XXX: Out = 0.
- Out depends only on the current A, B and ALUop. There is no internal state beyond the optional output register.

## Timing
- Without ALU_OUT_REG_EN: fully combinational path from inputs to Out and ALUop. Must settle within the 10 ns cycle; the bench samples 1 ns after an input change.
- With ALU_OUT_REG_EN:
  - Out is registered on the rising edge of Clock, giving 1-cycle latency.
  - ALUop stays combinational.
  - Reset_n low clears Out to 0 immediately (asynchronous); release is synchronous to Clock.
  - If reset is asserted mid-operation, the in-flight result is discarded.
- Reset value of ALUop: none, since it is combinational from inputs.

## Configuration
- ALU_OUT_REG_EN defined: Out is registered as described in Timing; reset value 0.
- ALU_OUT_REG_EN undefined: Out is combinational. Clock and Reset_n remain as ports but are unused and have no effect.

## Test plan
- opcode=0110011, funct=000, bit30=1, A=0x00000005, B=0x00000007 -> ALUop=1, Out=0xFFFFFFFE. With bit30=0 -> Out=0x0000000C.
- opcode=0010011, funct=101, bit30=1, A=0x80000000, B=0x00000024 (shamt 4) -> Out=0xF8000000. With bit30=0 -> Out=0x08000000.
- Compares on A=0xFFFFFFFF, B=0x00000001:
  - OP funct=010 (SLT) -> Out=0x00000001.
  - OP funct=011 (SLTU) -> Out=0x00000000.
- opcode=0110111 (LUI), A=0x12345678, B=0xABCDE000 -> ALUop=10, Out=0xABCDE000. opcode=0100011 (STORE), A=0x100, B=0xFFFFFFFC -> Out=0x000000FC.
- opcode=0010011, funct=000, bit30=1, A=1, B=1 -> ADDI ignores bit30, Out=2. opcode=1111111 -> ALUop=15, Out=0.
- With ALU_OUT_REG_EN:
  - Reset_n low -> Out=0 immediately.
  - After release, an ADD of 3+4 appears as Out=7 one Clock edge later.
  - Asserting Reset_n between edges clears Out asynchronously.

Source files
------------

// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU decoder and 32-bit integer ALU.
// Define ALU_OUT_REG_EN to register Out on Clock (async active-low Reset_n clears it).
module alu_exec_unit (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct,
  input  logic        add_rshift_type,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [3:0]  ALUop,
  output logic [31:0] Out
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_SLL    = 4'd5,
    OP_SRL    = 4'd6,
    OP_SRA    = 4'd7,
    OP_SLT    = 4'd8,
    OP_SLTU   = 4'd9,
    OP_COPY_B = 4'd10,
    OP_XXX    = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  alu_op_e     alu_op;
  logic [31:0] result;
  logic [4:0]  shamt;

  always_comb begin
    alu_op = OP_XXX;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (funct)
          3'b000: begin
            // ADDI has no SUB form; bit 30 belongs to the immediate there
            if (opcode == OPC_OP && add_rshift_type) alu_op = OP_SUB;
            else                                      alu_op = OP_ADD;
          end
          3'b001: alu_op = OP_SLL;
          3'b010: alu_op = OP_SLT;
          3'b011: alu_op = OP_SLTU;
          3'b100: alu_op = OP_XOR;
          3'b101: alu_op = add_rshift_type ? OP_SRA : OP_SRL;
          3'b110: alu_op = OP_OR;
          3'b111: alu_op = OP_AND;
          default: alu_op = OP_XXX;
        endcase
      end
      OPC_LUI: alu_op = OP_COPY_B;
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_BRANCH:
        alu_op = OP_ADD;
      default: alu_op = OP_XXX;
    endcase
  end

  assign ALUop = alu_op;
  assign shamt = B[4:0];

  always_comb begin
    result = '0;
    case (alu_op)
      OP_ADD:    result = A + B;
      OP_SUB:    result = A - B;
      OP_AND:    result = A & B;
      OP_OR:     result = A | B;
      OP_XOR:    result = A ^ B;
      OP_SLL:    result = A << shamt;
      OP_SRL:    result = A >> shamt;
      OP_SRA:    result = $unsigned($signed(A) >>> shamt);
      OP_SLT:    result = {31'd0, ($signed(A) < $signed(B))};
      OP_SLTU:   result = {31'd0, (A < B)};
      OP_COPY_B: result = B;
      default:   result = '0;
    endcase
  end

`ifdef ALU_OUT_REG_EN
  logic [31:0] out_d;
  logic [31:0] out_q;

  always_comb begin
    out_d = result;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) out_q <= '0;
    else          out_q <= out_d;
  end

  assign Out = out_q;
`else
  // Clock and Reset_n are kept as ports for a uniform footprint across builds
  logic unused_clk_rst;
  assign unused_clk_rst = Clock ^ Reset_n;

  assign Out = result;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven bench for alu_exec_unit; covers both output-register builds.
module tb_alu_exec_unit;

  logic        Clock;
  logic        Reset_n;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        add_rshift_type;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [31:0] Out;

  int vecs;
  int errs;

  alu_exec_unit dut (
    .Clock           (Clock),
    .Reset_n         (Reset_n),
    .opcode          (opcode),
    .funct           (funct),
    .add_rshift_type (add_rshift_type),
    .A               (A),
    .B               (B),
    .ALUop           (ALUop),
    .Out             (Out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        b30;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_op;
    logic [31:0] exp_out;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic b30,
                       input logic [31:0] a, input logic [31:0] b);
    opcode          = opc;
    funct           = f3;
    add_rshift_type = b30;
    A               = a;
    B               = b;
  endtask

  task automatic add(input string n, input logic [6:0] opc, input logic [2:0] f3,
                     input logic b30, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] eop, input logic [31:0] eout);
    vec_t v;
    v.name = n; v.opc = opc; v.f3 = f3; v.b30 = b30; v.a = a; v.b = b;
    v.exp_op = eop; v.exp_out = eout;
    tbl.push_back(v);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    Reset_n = 1'b0;
    drive(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd4);

    add("sub",        7'b0110011, 3'b000, 1'b1, 32'h00000005, 32'h00000007, 4'd1,  32'hFFFFFFFE);
    add("add",        7'b0110011, 3'b000, 1'b0, 32'h00000005, 32'h00000007, 4'd0,  32'h0000000C);
    add("srai",       7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'h00000024, 4'd7,  32'hF8000000);
    add("srli",       7'b0010011, 3'b101, 1'b0, 32'h80000000, 32'h00000024, 4'd6,  32'h08000000);
    add("slt_neg",    7'b0110011, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h00000001, 4'd8,  32'h00000001);
    add("sltu_big",   7'b0110011, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 4'd9,  32'h00000000);
    add("lui",        7'b0110111, 3'b000, 1'b0, 32'h12345678, 32'hABCDE000, 4'd10, 32'hABCDE000);
    add("store",      7'b0100011, 3'b010, 1'b0, 32'h00000100, 32'hFFFFFFFC, 4'd0,  32'h000000FC);
    add("addi_b30",   7'b0010011, 3'b000, 1'b1, 32'h00000001, 32'h00000001, 4'd0,  32'h00000002);
    add("bad_opc",    7'b1111111, 3'b000, 1'b0, 32'h12345678, 32'h9ABCDEF0, 4'd15, 32'h00000000);
    add("and",        7'b0110011, 3'b111, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd2,  32'h00F000F0);
    add("or_b30",     7'b0110011, 3'b110, 1'b1, 32'hF0F0F0F0, 32'h0F0F0000, 4'd3,  32'hFFFFF0F0);
    add("xor",        7'b0110011, 3'b100, 1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 4'd4,  32'hF0F00F0F);
    add("sll_hi_b",   7'b0110011, 3'b001, 1'b0, 32'h00000001, 32'hFFFFFFE3, 4'd5,  32'h00000008);
    add("slli",       7'b0010011, 3'b001, 1'b0, 32'h80000001, 32'h00000001, 4'd5,  32'h00000002);
    add("slt_pos",    7'b0110011, 3'b010, 1'b0, 32'h00000001, 32'hFFFFFFFF, 4'd8,  32'h00000000);
    add("sltu_small", 7'b0110011, 3'b011, 1'b0, 32'h00000001, 32'hFFFFFFFF, 4'd9,  32'h00000001);
    add("slti_min",   7'b0010011, 3'b010, 1'b0, 32'h80000000, 32'h00000000, 4'd8,  32'h00000001);
    add("sltiu_eq",   7'b0010011, 3'b011, 1'b0, 32'h00000005, 32'h00000005, 4'd9,  32'h00000000);
    add("srl_31",     7'b0110011, 3'b101, 1'b0, 32'hFFFFFFFF, 32'h0000001F, 4'd6,  32'h00000001);
    add("sra_pos",    7'b0110011, 3'b101, 1'b1, 32'h7FFFFFFF, 32'h0000001F, 4'd7,  32'h00000000);
    add("add_wrap",   7'b0110011, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000001, 4'd0,  32'h00000000);
    add("sub_wrap",   7'b0110011, 3'b000, 1'b1, 32'h00000000, 32'h00000001, 4'd1,  32'hFFFFFFFF);
    add("jal",        7'b1101111, 3'b000, 1'b0, 32'h00001000, 32'h00000004, 4'd0,  32'h00001004);
    add("jalr",       7'b1100111, 3'b000, 1'b0, 32'h00002000, 32'hFFFFFFF0, 4'd0,  32'h00001FF0);
    add("branch",     7'b1100011, 3'b001, 1'b1, 32'h00000400, 32'hFFFFFF00, 4'd0,  32'h00000300);
    add("auipc",      7'b0010111, 3'b000, 1'b0, 32'h00000010, 32'h12345000, 4'd0,  32'h12345010);
    add("load",       7'b0000011, 3'b010, 1'b0, 32'h00000008, 32'h00000008, 4'd0,  32'h00000010);
    add("zero_opc",   7'b0000000, 3'b000, 1'b0, 32'h00000001, 32'h00000001, 4'd15, 32'h00000000);
    add("system",     7'b1110011, 3'b000, 1'b0, 32'h00000001, 32'h00000001, 4'd15, 32'h00000000);

`ifdef ALU_OUT_REG_EN
    // reset held: Out stays 0 across edges even with an ADD presented
    #1;
    check("reset_out", Out, 32'h0);
    @(posedge Clock); #1;
    check("reset_held_out", Out, 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    #1;
    check("release_no_edge", Out, 32'h0);
    @(posedge Clock); #1;
    check("add_3_4_latency", Out, 32'd7);
    // async clear between edges
    @(negedge Clock);
    drive(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3);
    #1;
    check("no_comb_leak", Out, 32'd7);
    @(posedge Clock); #1;
    check("sub_10_3", Out, 32'd7 + 32'd0);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_clear", Out, 32'h0);
    @(posedge Clock); #1;
    check("inflight_discard", Out, 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    check("post_reset_sub", Out, 32'd7);

    foreach (tbl[i]) begin
      @(negedge Clock);
      drive(tbl[i].opc, tbl[i].f3, tbl[i].b30, tbl[i].a, tbl[i].b);
      #1;
      check({tbl[i].name, "_aluop"}, {28'd0, ALUop}, {28'd0, tbl[i].exp_op});
      @(posedge Clock); #1;
      check({tbl[i].name, "_out"}, Out, tbl[i].exp_out);
    end
`else
    // Clock and Reset_n must not affect the combinational result
    #1;
    check("comb_in_reset", Out, 32'd7);
    check("comb_in_reset_op", {28'd0, ALUop}, 32'd0);
    @(posedge Clock); #1;
    check("comb_after_edge", Out, 32'd7);
    Reset_n = 1'b1;
    #1;
    check("comb_after_release", Out, 32'd7);

    foreach (tbl[i]) begin
      drive(tbl[i].opc, tbl[i].f3, tbl[i].b30, tbl[i].a, tbl[i].b);
      #1;
      check({tbl[i].name, "_aluop"}, {28'd0, ALUop}, {28'd0, tbl[i].exp_op});
      check({tbl[i].name, "_out"}, Out, tbl[i].exp_out);
      #3;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion, expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
